// File: rtl/state_trace_pkg.sv
// Shared definitions for the state trace checker: state encodings, record layout
// helpers and the legal-successor function.
package state_trace_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_e;

  localparam int unsigned STATE_W = 2;

  // Record layout, LSB first: dwell[DW-1:0], aux[1:0], new[1:0], prev[1:0], illegal
  function automatic int unsigned rec_width(input int unsigned dw);
    return dw + 7;
  endfunction

  function automatic int unsigned off_dwell(input int unsigned dw);
    return 0 + (dw - dw);
  endfunction

  function automatic int unsigned off_aux(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned off_new(input int unsigned dw);
    return dw + 2;
  endfunction

  function automatic int unsigned off_prev(input int unsigned dw);
    return dw + 4;
  endfunction

  function automatic int unsigned off_illegal(input int unsigned dw);
    return dw + 6;
  endfunction

  // Legal successor in the 0->1->2->3->0 cycle
  function automatic logic [1:0] next_state(input logic [1:0] s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/state_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers, registered occupancy count and no
// write-to-read bypass. A push into a full FIFO is accepted only alongside a pop.
module state_trace_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = count_q;

  // Storage array; cleared on reset so the head reads zero when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/state_trace_checker.sv
// Watches the upstream state code, measures dwell per state, checks transition
// legality and queues one record per transition for a valid/ready consumer.
// Build option: define STATE_TRACE_CHECK_EN to compile in the legality check
// (illegal bit and sticky err); otherwise illegal=0 and err=0.
module state_trace_checker
  import state_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 dout0,
  input  logic [1:0]                 dout1,
  input  logic                       clr,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [DW+6:0]              evt_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err,
  output logic                       ovf
);

  localparam int unsigned RW = rec_width(DW);

  logic          primed_q, primed_d;
  logic [1:0]    last_q, last_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          ovf_q, ovf_d;
  logic          change_c, illegal_c, pop_c, full_c, empty_c;
  logic [RW-1:0] rec_c;

  assign change_c  = en & primed_q & (dout0 != last_q);
  assign evt_valid = ~empty_c;
  assign pop_c     = evt_valid & evt_ready;
  assign rec_c     = {illegal_c, last_q, dout0, dout1, dwell_q};
  assign ovf       = ovf_q;

`ifdef STATE_TRACE_CHECK_EN
  logic err_q, err_d;

  assign illegal_c = (dout0 != next_state(last_q));
  assign err       = err_q;

  // Sticky illegal-transition flag; clear wins over set
  always_comb begin
    err_d = err_q;
    if (clr)                       err_d = 1'b0;
    else if (change_c & illegal_c) err_d = 1'b1;
  end

  // Illegal flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign illegal_c = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state for priming, last-state tracking, dwell counting and overflow flag
  always_comb begin
    primed_d = primed_q;
    last_d   = last_q;
    dwell_d  = dwell_q;
    ovf_d    = ovf_q;
    if (en) begin
      if (!primed_q) begin
        primed_d = 1'b1;
        last_d   = dout0;
        dwell_d  = DW'(1);
      end else if (change_c) begin
        last_d   = dout0;
        dwell_d  = DW'(1);
      end else if (dwell_q != {DW{1'b1}}) begin
        dwell_d  = dwell_q + DW'(1);
      end
    end
    if (clr)                                ovf_d = 1'b0;
    else if (change_c & full_c & ~pop_c)    ovf_d = 1'b1;
  end

  // Tracking state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= 1'b0;
      last_q   <= 2'd0;
      dwell_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      primed_q <= primed_d;
      last_q   <= last_d;
      dwell_q  <= dwell_d;
      ovf_q    <= ovf_d;
    end
  end

  state_trace_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (change_c),
    .pop_i   (pop_c),
    .data_i  (rec_c),
    .data_o  (evt_data),
    .full_o  (full_c),
    .empty_o (empty_c),
    .count_o (count)
  );

endmodule

// File: tb/tb_state_trace_checker.sv
// Directed bench for state_trace_checker: expected records are queued as stimulus
// is issued and a forked monitor compares them as the consumer pops.
module tb_state_trace_checker;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 8;
`ifdef STATE_TRACE_CHECK_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  dout0, dout1;
  logic        clr;
  logic        evt_ready;
  logic        evt_valid;
  logic [14:0] evt_data;
  logic [2:0]  count;
  logic        err, ovf;

  int n_checks = 0;
  int n_fails  = 0;
  logic [14:0] exp_q [$];

  state_trace_checker #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dout0     (dout0),
    .dout1     (dout1),
    .clr       (clr),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .count     (count),
    .err       (err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input bit ill, input logic [1:0] p, input logic [1:0] n,
                                     input logic [1:0] a, input logic [7:0] d);
    return {ill, p, n, a, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 32'(evt_data), 32'hFFFF_FFFF);
        end else begin
          chk("record", 32'(evt_data), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic step(input logic [1:0] d0, input logic [1:0] d1);
    en = 1'b1; dout0 = d0; dout1 = d1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clr();
    en = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk); #1; k++; end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dout0 = 2'd0; dout1 = 2'd0; clr = 1'b0; evt_ready = 1'b0;
    fork monitor(); join_none

    // Reset values
    #12;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_data",  32'(evt_data),  32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 0,0,0,1: prime plus two holds, dwell 3
    evt_ready = 1'b1;
    step(2'd0, 2'd0); step(2'd0, 2'd0); step(2'd0, 2'd0);
    chk("prime_no_record", 32'(evt_valid), 32'd0);
    exp_q.push_back(mk(1'b0, 2'd0, 2'd1, 2'd2, 8'd3));
    step(2'd1, 2'd2);
    chk("latency_valid", 32'(evt_valid), 32'd1);
    chk("latency_count", 32'(count),     32'd1);

    // Illegal 1->3, then clear
    step(2'd1, 2'd0);
    exp_q.push_back(mk(ILL, 2'd1, 2'd3, 2'd1, 8'd2));
    step(2'd3, 2'd1);
    chk("err_set", 32'(err), 32'(ILL));
    pulse_clr();
    chk("err_clr", 32'(err), 32'd0);

    // Disabled cycles: dout0 changes ignored, dwell frozen
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dout0 = 2'(i);
      @(posedge clk); #1;
    end
    chk("dis_valid", 32'(evt_valid), 32'd0);
    chk("dis_count", 32'(count),     32'd0);
    step(2'd3, 2'd0); step(2'd3, 2'd0);
    exp_q.push_back(mk(1'b0, 2'd3, 2'd0, 2'd3, 8'd3));
    step(2'd0, 2'd3);

    // Long hold saturates dwell
    for (int i = 0; i < 300; i++) step(2'd0, 2'd0);
    exp_q.push_back(mk(1'b0, 2'd0, 2'd1, 2'd0, 8'd255));
    step(2'd1, 2'd0);

    // Overflow: consumer stalled, 5 transitions into depth 4
    idle(3);
    evt_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 2'd1, 2'd2, 2'd1, 8'd1));
    exp_q.push_back(mk(1'b0, 2'd2, 2'd3, 2'd1, 8'd1));
    exp_q.push_back(mk(1'b0, 2'd3, 2'd0, 2'd1, 8'd1));
    exp_q.push_back(mk(1'b0, 2'd0, 2'd1, 2'd1, 8'd1));
    step(2'd2, 2'd1); step(2'd3, 2'd1); step(2'd0, 2'd1); step(2'd1, 2'd1); step(2'd2, 2'd1);
    idle(2);
    chk("full_count", 32'(count),     32'd4);
    chk("ovf_set",    32'(ovf),       32'd1);
    chk("full_valid", 32'(evt_valid), 32'd1);
    chk("head_hold",  32'(evt_data),  32'(mk(1'b0, 2'd1, 2'd2, 2'd1, 8'd1)));
    chk("err_legal",  32'(err),       32'd0);
    evt_ready = 1'b1;
    wait_drain("drain_ovf");
    chk("drain_count", 32'(count), 32'd0);
    pulse_clr();
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Reset with records queued
    evt_ready = 1'b0;
    step(2'd3, 2'd0); step(2'd0, 2'd0); step(2'd1, 2'd0);
    chk("queued_count", 32'(count), 32'd3);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(evt_valid), 32'd0);
    chk("arst_count", 32'(count),     32'd0);
    @(posedge clk); #1; rst = 1'b0;
    evt_ready = 1'b1;
    step(2'd2, 2'd0);
    chk("reprime_valid", 32'(evt_valid), 32'd0);
    exp_q.push_back(mk(1'b0, 2'd2, 2'd3, 2'd1, 8'd1));
    step(2'd3, 2'd1);
    chk("post_rst_valid", 32'(evt_valid), 32'd1);
    idle(1);
    wait_drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/state_trace_checker.md
# state_trace_checker

Downstream consumer of the two-bit state outputs (`dout0`, `dout1`) of the state-machine stage.
- Watches `dout0` for state changes and measures how long each state was held (dwell).
- Checks each transition against the legal sequence 0→1→2→3→0.
- Pushes one transition record per change into a small FIFO, drained by a valid/ready interface toward a logger or bus.

## Interface
- `DEPTH`, 4: FIFO depth in records; power of two, ≥2.
- `DW`, 8: dwell counter width; saturating.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: sample enable; same signal that enables the upstream state machine.
- `dout0` input 2: state code from upstream.
- `dout1` input 2: auxiliary upstream output; captured into each record.
- `clr` input 1: synchronous clear of the sticky flags `err` and `ovf`.
- `evt_ready` input 1: consumer accepts the record.
- `evt_valid` output 1: FIFO not empty.
- `evt_data` output DW+7: head record = {illegal, prev[1:0], new[1:0], aux[1:0], dwell[DW-1:0]} (MSB first).
- `count` output $clog2(DEPTH+1): number of records held in the FIFO.
- `err` output 1: sticky flag, illegal transition seen.
- `ovf` output 1: sticky flag, record dropped because the FIFO was full.

## Operation
- **Internal state:** `primed`, `last[1:0]`, `dwell_cnt[DW-1:0]`, FIFO, `err`, `ovf`.
- **en=0:** all internal state holds; no push. FIFO pops still occur on `evt_valid & evt_ready`.
- **First enabled cycle after reset (`primed`=0):**
  - `last` ← `dout0`, `dwell_cnt` ← 1, `primed` ← 1.
  - No record is pushed.
- **Enabled cycle with `dout0 == last`:** `dwell_cnt` increments, saturating at 2^DW−1.
- **Enabled cycle with `dout0 != last` (a transition):**
  - Build record: prev=`last`, new=`dout0`, aux=`dout1`, dwell=`dwell_cnt`, illegal=(`dout0 != last+1` mod 4).
  - Push the record; then `last` ← `dout0`, `dwell_cnt` ← 1.
  - If illegal=1, `err` ← 1.
- **FIFO full on push:**
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the record is dropped and `ovf` ← 1. The `last`/`dwell_cnt` update still happens.
- **Pop:** occurs when `evt_valid & evt_ready`. `evt_data` is the head record and stays stable while `evt_valid=1 & evt_ready=0`.
- **No bypass:** with the FIFO empty, a record pushed at edge k is visible after edge k.
- **Sticky flags:** `clr` has priority over a set in the same cycle (the flag reads 0 after that edge).
- **Wrap-around:** FIFO pointers are $clog2(DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; empty when the pointers are equal.

## Timing
- **Reset values:** `evt_valid`=0, `evt_data`=0, `count`=0, `err`=0, `ovf`=0, `primed`=0, `last`=0, `dwell_cnt`=0.
- **Latency:** `dout0` change sampled at edge k → `evt_valid`=1 and the record on `evt_data` after edge k (1 cycle).
- **`count`:** registered; updates on the same edge as the push/pop.
- **Reset mid-operation:**
  - Asynchronous: all registers clear immediately and the FIFO contents are discarded.
  - The first enabled cycle after reset re-primes the block with no push.
- **Simultaneous push + pop when empty:** not possible, since `evt_valid`=0. Only the push takes effect.

## Configuration
- **`STATE_TRACE_CHECK_EN` defined:** legality check compiled in; `illegal` and `err` behave as described above.
- **Not defined:**
  - `illegal` bit is forced to 0 and `err` is tied to 0.
  - `clr` affects only `ovf`.
  - Record width is unchanged.

## Structure
- **Package `state_trace_pkg`:**
  - Record field offsets and width function of DW.
  - State encodings S0..S3 = 0..3.
  - Function `next_state(s) = s+1` mod 4.
- **Sub-module `state_trace_fifo`:** synchronous FIFO parameterised by width and depth, with push/pop/full/empty/count. The top level holds the detection, dwell and flag logic.

## Test plan
- **Reset, then en=1 with `dout0` stepping 0,0,0,1:** one record {0,0,1,aux,3}; `evt_valid` rises the cycle after 1 is sampled.
- **Illegal jump 1→3:** record illegal=1 and `err`=1. Pulsing `clr` returns `err` to 0.
- **`evt_ready`=0 with 5 transitions at DEPTH=4:** `count`=4, `ovf`=1, and the 5th record is lost. Draining then returns the first 4 records in order.
- **Hold state for 300 cycles with DW=8:** dwell field = 255 (saturated).
- **en=0 for 10 cycles while `dout0` changes, then en=1:** no record is produced during en=0. The dwell count excludes the disabled cycles.
- **Assert `rst` with 3 records queued:** `evt_valid`=0 and `count`=0 immediately. The first enabled sample after reset produces no record.
